// File: rtl/cordic_sincos_if.sv
// Request/result handshake bundle for cordic_sincos: angle request in, sin/cos result out.
// The design drives the slave view and the requester/consumer drives the master view.
interface cordic_sincos_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] angle;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] cos_out;
  logic signed [31:0] sin_out;

  modport master (
    output in_valid, angle, out_ready,
    input  in_ready, out_valid, cos_out, sin_out
  );

  modport slave (
    input  in_valid, angle, out_ready,
    output in_ready, out_valid, cos_out, sin_out
  );
endinterface

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC sin/cos in Q16.16, one micro-rotation per clock on a shared datapath.
// Define CORDIC_SINCOS_QUADRANT_FOLD_EN to widen the input range to [-pi,+pi] via a quadrant fold.
module cordic_sincos #(
  parameter int NITER = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  cordic_sincos_if.slave  bus
);

  localparam logic signed [31:0] GAIN_K   = 32'sh0000_9B75;
  localparam logic signed [31:0] HALF_PI  = 32'sh0001_921F;
  localparam logic signed [31:0] NEG_HALF = -32'sh0001_921F;
  localparam logic [4:0]         LAST     = 5'(NITER);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t             state;
  logic               in_ready_q;
  logic               out_valid_q;
  logic signed [31:0] cos_q, sin_q;
  logic signed [31:0] x, y, z;
  logic [4:0]         iter;

  logic               dir;
  logic signed [31:0] x_sh, y_sh, atan_i;
  logic signed [31:0] x_nxt, y_nxt, z_nxt;
  logic signed [31:0] z_init, cos_fin, sin_fin;

  // round(atan(2^-i) * 65536)
  function automatic logic signed [31:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 32'sh0000_C910;
      4'd1:    atan_lut = 32'sh0000_76B2;
      4'd2:    atan_lut = 32'sh0000_3EB7;
      4'd3:    atan_lut = 32'sh0000_1FD6;
      4'd4:    atan_lut = 32'sh0000_0FFB;
      4'd5:    atan_lut = 32'sh0000_07FF;
      4'd6:    atan_lut = 32'sh0000_0400;
      4'd7:    atan_lut = 32'sh0000_0200;
      4'd8:    atan_lut = 32'sh0000_0100;
      4'd9:    atan_lut = 32'sh0000_0080;
      4'd10:   atan_lut = 32'sh0000_0040;
      4'd11:   atan_lut = 32'sh0000_0020;
      4'd12:   atan_lut = 32'sh0000_0010;
      4'd13:   atan_lut = 32'sh0000_0008;
      4'd14:   atan_lut = 32'sh0000_0004;
      default: atan_lut = 32'sh0000_0002;
    endcase
  endfunction

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    dir    = ~z[31];
    x_sh   = x >>> iter;
    y_sh   = y >>> iter;
    atan_i = atan_lut(iter[3:0]);
    x_nxt  = dir ? x - y_sh   : x + y_sh;
    y_nxt  = dir ? y + x_sh   : y - x_sh;
    z_nxt  = dir ? z - atan_i : z + atan_i;
  end

`ifdef CORDIC_SINCOS_QUADRANT_FOLD_EN
  localparam logic signed [31:0] PI     = 32'sh0003_243F;
  localparam logic signed [31:0] NEG_PI = -32'sh0003_243F;

  logic               neg_init, neg;
  logic signed [31:0] clamped;

  // Outer quadrants rotate by pi into the CORDIC convergence range; the result is negated back.
  always_comb begin
    if (bus.angle > PI)          clamped = PI;
    else if (bus.angle < NEG_PI) clamped = NEG_PI;
    else                         clamped = bus.angle;
    neg_init = 1'b0;
    z_init   = clamped;
    if (clamped > HALF_PI) begin
      z_init   = clamped - PI;
      neg_init = 1'b1;
    end else if (clamped < NEG_HALF) begin
      z_init   = clamped + PI;
      neg_init = 1'b1;
    end
    cos_fin = neg ? -x : x;
    sin_fin = neg ? -y : y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       neg <= 1'b0;
    else if (state == IDLE && in_ready_q && bus.in_valid) neg <= neg_init;
  end
`else
  always_comb begin
    if (bus.angle > HALF_PI)       z_init = HALF_PI;
    else if (bus.angle < NEG_HALF) z_init = NEG_HALF;
    else                           z_init = bus.angle;
    cos_fin = x;
    sin_fin = y;
  end
`endif

  // The extra ITER pass with iter==NITER registers the finished vector, giving NITER+1 cycles of latency.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cos_q       <= '0;
      sin_q       <= '0;
      x           <= '0;
      y           <= '0;
      z           <= '0;
      iter        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            x          <= GAIN_K;
            y          <= '0;
            z          <= z_init;
            iter       <= '0;
            state      <= ITER;
          end
        end
        ITER: begin
          if (iter == LAST) begin
            cos_q       <= cos_fin;
            sin_q       <= sin_fin;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            x    <= x_nxt;
            y    <= y_nxt;
            z    <= z_nxt;
            iter <= iter + 5'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cos_out   = cos_q;
  assign bus.sin_out   = sin_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed bench for cordic_sincos: reference angles, latency, backpressure and mid-run reset.
// Expected values for the +/-pi vectors follow CORDIC_SINCOS_QUADRANT_FOLD_EN when defined.
module tb_cordic_sincos;

  localparam int NITER = 16;
  localparam int TOL   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  cordic_sincos_if bus ();

  cordic_sincos #(.NITER(NITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                       input int tol = 0);
    int diff;
    diff = $signed(got) - $signed(exp);
    n_tests++;
    if (diff < -tol || diff > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input string tag, input logic [31:0] a);
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check({tag, "_ready_wait"}, 32'd0, 32'd1);
    bus.angle    = a;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.angle    = 32'hDEAD_BEEF;
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.out_valid && lat < 100);
    check({tag, "_latency"}, 32'(lat), 32'(NITER + 1));
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_cos, input logic [31:0] exp_sin);
    start(tag, a);
    check({tag, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
    wait_result(tag);
    check({tag, "_cos"}, bus.cos_out, exp_cos, TOL);
    check({tag, "_sin"}, bus.sin_out, exp_sin, TOL);
    consume(tag);
  endtask

  string       tags   [6];
  logic [31:0] angles [6];
  logic [31:0] coses  [6];
  logic [31:0] sines  [6];

  initial begin
    tags[0] = "zero";    angles[0] = 32'h0000_0000; coses[0] = 32'h0001_0000; sines[0] = 32'h0000_0000;
    tags[1] = "pi6";     angles[1] = 32'h0000_860A; coses[1] = 32'h0000_DDB4; sines[1] = 32'h0000_8000;
    tags[2] = "neg_pi6"; angles[2] = 32'hFFFF_79F6; coses[2] = 32'h0000_DDB4; sines[2] = 32'hFFFF_8000;
    tags[3] = "pi4";     angles[3] = 32'h0000_C910; coses[3] = 32'h0000_B505; sines[3] = 32'h0000_B505;
`ifdef CORDIC_SINCOS_QUADRANT_FOLD_EN
    tags[4] = "pi";      angles[4] = 32'h0003_243F; coses[4] = 32'hFFFF_0000; sines[4] = 32'h0000_0000;
    tags[5] = "neg_pi";  angles[5] = 32'hFFFC_DBC1; coses[5] = 32'hFFFF_0000; sines[5] = 32'h0000_0000;
`else
    tags[4] = "pi";      angles[4] = 32'h0003_243F; coses[4] = 32'h0000_0000; sines[4] = 32'h0001_0000;
    tags[5] = "neg_pi";  angles[5] = 32'hFFFC_DBC1; coses[5] = 32'h0000_0000; sines[5] = 32'hFFFF_0000;
`endif

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.angle     = 32'h0;

    // Reset state
    #2;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_cos",       bus.cos_out,            32'd0);
    check("rst_sin",       bus.sin_out,            32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 6; i++) run_vec(tags[i], angles[i], coses[i], sines[i]);

    // Backpressure: result must hold while in_valid pulses are ignored
    start("bp", 32'h0000_860A);
    wait_result("bp");
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = c[0];
      bus.angle    = 32'h0000_0000;
      tick();
      check("bp_valid_hold", {31'd0, bus.out_valid}, 32'd1);
      check("bp_ready_low",  {31'd0, bus.in_ready},  32'd0);
      check("bp_cos_hold",   bus.cos_out, 32'h0000_DDB4, TOL);
      check("bp_sin_hold",   bus.sin_out, 32'h0000_8000, TOL);
    end
    bus.in_valid = 1'b0;
    consume("bp");
    repeat (3) tick();
    check("bp_no_phantom", {31'd0, bus.out_valid}, 32'd0);
    check("bp_idle_ready", {31'd0, bus.in_ready},  32'd1);

    // Mid-ITER reset abandons the computation
    start("rst_mid", 32'h0000_C910);
    repeat (7) tick();
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_cos",   bus.cos_out,            32'd0);
    check("mid_rst_sin",   bus.sin_out,            32'd0);
    check("mid_rst_ready", {31'd0, bus.in_ready},  32'd0);
    tick();
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 25; c++) begin
        tick();
        if (bus.out_valid) seen++;
      end
      check("mid_rst_no_emit", 32'(seen), 32'd0);
    end
    run_vec("after_rst", 32'h0000_860A, 32'h0000_DDB4, 32'h0000_8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before 1000000");
    $fatal(1);
  end

endmodule
